laser_cover_param: RTL and testbench
====================================

// Module: laser_cover_param
// PURPOSE
//  Parametrised two-circle coverage engine. Loads NPTS grid points, then
//  searches all grid centres for two discs of radius RADIUS that together
//  cover the most points, using alternating refinement. Adds an input
//  handshake, Euclidean radius and a bounded round count. Sits between the
//  point-stream front end and the result collector.
// PARAMETERS
//  NPTS       40  points per job (2..63)
//  CW         4   coordinate width; grid is 2^CW x 2^CW
//  RADIUS     4   disc radius; covered iff dx^2+dy^2 <= RADIUS^2
//  MAX_ROUNDS 8   max refinement rounds (one round = C1 sweep + C2 sweep)
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   reset, asynchronous, active-high
//  IN_VALID  in   1   X/Y carry a valid point this cycle
//  X, Y      in   CW  point coordinates
//  READY     out  1   block accepts points (LOAD state)
//  C1X, C1Y  out  CW  centre of disc 1, registered
//  C2X, C2Y  out  CW  centre of disc 2, registered
//  DONE      out  1   one-cycle pulse: C1/C2 valid for this job
//  CNT       out  6   union cover count (only with LASER_COUNT_OUT_EN)
// BEHAVIOUR
//  - Reset: state=LOAD, READY=1, DONE=0, C1*/C2*=0, CNT=0, point count=0.
//  - Accept a point when IN_VALID & READY. Points are stored in arrival
//    order; duplicates count separately. IN_VALID is ignored while READY=0.
//  - After the NPTS-th accept, READY drops the next cycle.
//  - Sweep: candidates in raster order, y outer 0..2^CW-1, x inner;
//    1 candidate/cycle throughput. Pipeline depth PIPE<=4 is allowed;
//    results are defined by the algorithm, not the pipeline.
//  - Distance: dx, dy as CW+1-bit signed; dx^2+dy^2 in 2*CW+1 bits, unsigned
//    compare against RADIUS^2. Candidates include edge/corner cells.
//  - States:
//    LOAD   -> SWEEP1 after NPTS accepts.
//    SWEEP1 : C1 alone; best starts at -1; replace on strictly greater
//             (ties keep lowest raster index). -> SWEEP2, C1=best.
//    SWEEP2 : C2 sweep, C1 fixed, union count; best starts at -1, strict >.
//             -> REF1, C2=best, U=union.
//    REF1   : C1 sweep, C2 fixed; best starts at U; strict > updates C1, U.
//             -> REF2.
//    REF2   : same for C2 with C1 fixed. -> OUT if no update in REF1 or
//             REF2 this round, or MAX_ROUNDS rounds done; else -> REF1.
//    OUT    : DONE=1 for one cycle -> LOAD (READY=1 next cycle, count=0).
//  - C1X..C2Y update only on entry to OUT; held until the next job's OUT.
//  - Latency bound: last accept to DONE <= (2+2*MAX_ROUNDS)*(2^(2*CW)+PIPE)+4.
//  - RST mid-job (any state): immediate return to reset values; partial
//    points and search state discarded.
//  - No point covered by any centre cannot occur (every point covers itself);
//    U >= 1 always.
// CONFIGURATION
//  LASER_COUNT_OUT_EN defined: CNT port present, loaded with final U on
//    entry to OUT, held until next OUT, reset 0.
//  Not defined: no CNT port; U kept internal only. All else identical.
// TESTING
//  1 All 40 pts (8,8), NPTS=40 -> DONE, C1=(8,4), C2=(0,0), CNT=40.
//  2 20 pts (2,2) + 20 pts (13,13) interleaved -> C1=(0,0), C2=(13,9),
//    CNT=40.
//  3 All 40 pts (15,15) -> C1=(15,11), C2=(0,0); edge candidates legal.
//  4 Test 2 with random IN_VALID bubbles and IN_VALID=1 during search ->
//    identical outputs; extra points ignored; READY=0 from after accept 40
//    until after DONE.
//  5 RST pulse mid-SWEEP2 -> outputs 0, READY=1, no DONE; reload test 1
//    -> test 1 result.
//  6 Back-to-back jobs (test 1 then test 2) -> two DONE pulses; outputs
//    held between; latency within bound each job.

Source files
------------

// File: rtl/laser_cover_param.sv
// Two-disc coverage engine: loads NPTS points, then alternately refines two disc centres.
// Optional CNT output (final union count) is enabled by defining LASER_COUNT_OUT_EN.
module laser_cover_param #(
   parameter int NPTS       = 40,
   parameter int CW         = 4,
   parameter int RADIUS     = 4,
   parameter int MAX_ROUNDS = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   input  logic [CW-1:0] X,
   input  logic [CW-1:0] Y,
   output logic          READY,
   output logic [CW-1:0] C1X,
   output logic [CW-1:0] C1Y,
   output logic [CW-1:0] C2X,
   output logic [CW-1:0] C2Y,
   output logic          DONE
`ifdef LASER_COUNT_OUT_EN
   ,
   output logic [5:0]    CNT
`endif
);

   localparam int PW = $clog2(NPTS);
   localparam int RW = $clog2(MAX_ROUNDS + 1);
   localparam logic [2*CW+1:0] R2 = (2*CW+2)'(RADIUS * RADIUS);

   typedef enum logic [2:0] {
      ST_LOAD, ST_SWEEP1, ST_SWEEP2, ST_REF1, ST_REF2, ST_OUT
   } state_t;

   state_t state_q, state_d;

   logic [5:0]        pcnt_q;
   logic [CW-1:0]     px [NPTS];
   logic [CW-1:0]     py [NPTS];
   logic [2*CW-1:0]   cand_q;
   logic [CW-1:0]     w1x, w1y, w2x, w2y;
   logic [CW-1:0]     bpx, bpy;
   logic signed [6:0] best_q;
   logic              upd_q;
   logic [RW-1:0]     round_q;

   logic [CW-1:0]     cx, cy, fx, fy, npx, npy;
   logic              use_fixed, take, last, accept;
   logic [5:0]        cnt_c;
   logic signed [6:0] nb;

   function automatic logic covers(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                   input logic [CW-1:0] bx, input logic [CW-1:0] by);
      logic signed [CW:0]     dx, dy;
      logic signed [2*CW+1:0] sqx, sqy;
      logic [2*CW+1:0]        d2;
      dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
      sqx = dx * dx;
      sqy = dy * dy;
      d2  = sqx + sqy;
      return (d2 <= R2);
   endfunction

   assign cx        = cand_q[CW-1:0];
   assign cy        = cand_q[2*CW-1:CW];
   assign fx        = (state_q == ST_REF1) ? w2x : w1x;
   assign fy        = (state_q == ST_REF1) ? w2y : w1y;
   assign use_fixed = (state_q != ST_SWEEP1);
   assign last      = &cand_q;
   assign accept    = IN_VALID && (state_q == ST_LOAD);
   assign READY     = (state_q == ST_LOAD);
   assign DONE      = (state_q == ST_OUT);

   // Union count for the sweeping candidate against the fixed disc (if any).
   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < NPTS; i++) begin
         if (covers(cx, cy, px[i], py[i]) || (use_fixed && covers(fx, fy, px[i], py[i])))
            cnt_c = cnt_c + 6'd1;
      end
   end

   assign take = ($signed({1'b0, cnt_c}) > best_q);
   assign nb   = take ? $signed({1'b0, cnt_c}) : best_q;
   assign npx  = take ? cx : bpx;
   assign npy  = take ? cy : bpy;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_LOAD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:   if (accept && pcnt_q == 6'(NPTS - 1)) state_d = ST_SWEEP1;
         ST_SWEEP1: if (last) state_d = ST_SWEEP2;
         ST_SWEEP2: if (last) state_d = ST_REF1;
         ST_REF1:   if (last) state_d = ST_REF2;
         ST_REF2:
            if (last) begin
               if (!(upd_q || take) || round_q == RW'(MAX_ROUNDS - 1)) state_d = ST_OUT;
               else                                                   state_d = ST_REF1;
            end
         ST_OUT:    state_d = ST_LOAD;
         default:   state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         px[pcnt_q[PW-1:0]] <= X;
         py[pcnt_q[PW-1:0]] <= Y;
      end
   end

   // best_q holds the running best; during REF sweeps it starts at (and ends as) U.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt_q  <= '0;
         cand_q  <= '0;
         w1x     <= '0;  w1y <= '0;  w2x <= '0;  w2y <= '0;
         bpx     <= '0;  bpy <= '0;
         best_q  <= '1;
         upd_q   <= 1'b0;
         round_q <= '0;
         C1X     <= '0;  C1Y <= '0;  C2X <= '0;  C2Y <= '0;
`ifdef LASER_COUNT_OUT_EN
         CNT     <= '0;
`endif
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (accept) pcnt_q <= pcnt_q + 6'd1;
               cand_q  <= '0;
               best_q  <= '1;
               bpx     <= '0;  bpy <= '0;
               upd_q   <= 1'b0;
               round_q <= '0;
            end
            ST_SWEEP1, ST_SWEEP2, ST_REF1, ST_REF2: begin
               cand_q <= cand_q + 1'b1;
               best_q <= nb;
               bpx    <= npx;
               bpy    <= npy;
               if (take) upd_q <= 1'b1;
               if (last) begin
                  case (state_q)
                     ST_SWEEP1: begin
                        w1x <= npx;  w1y <= npy;
                        best_q <= '1;
                        bpx <= '0;  bpy <= '0;
                     end
                     ST_SWEEP2: begin
                        w2x <= npx;  w2y <= npy;
                        bpx <= w1x;  bpy <= w1y;
                        upd_q <= 1'b0;
                     end
                     ST_REF1: begin
                        w1x <= npx;  w1y <= npy;
                        bpx <= w2x;  bpy <= w2y;
                     end
                     default: begin
                        w2x <= npx;  w2y <= npy;
                        bpx <= w1x;  bpy <= w1y;
                        upd_q   <= 1'b0;
                        round_q <= round_q + 1'b1;
                        if (state_d == ST_OUT) begin
                           C1X <= w1x;  C1Y <= w1y;
                           C2X <= npx;  C2Y <= npy;
`ifdef LASER_COUNT_OUT_EN
                           CNT <= nb[5:0];
`endif
                        end
                     end
                  endcase
               end
            end
            ST_OUT:  pcnt_q <= '0;
            default: pcnt_q <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_laser_cover_param.sv
// Directed bench for laser_cover_param: scoreboard of expected centres popped on each DONE.
module tb_laser_cover_param;

   localparam int CW    = 4;
   localparam int NPTS  = 40;
   localparam int MAXR  = 8;
   localparam int BOUND = (2 + 2*MAXR) * ((1 << (2*CW)) + 4) + 4;
   localparam int LIMIT = 6000;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [CW-1:0] x, y;
   logic          ready, done;
   logic [CW-1:0] c1x, c1y, c2x, c2y;
`ifdef LASER_COUNT_OUT_EN
   logic [5:0]    cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [21:0] exp_q[$];
   logic [21:0] prev_exp;

   laser_cover_param #(.NPTS(NPTS), .CW(CW), .RADIUS(4), .MAX_ROUNDS(MAXR)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .X(x), .Y(y), .READY(ready),
      .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .DONE(done)
`ifdef LASER_COUNT_OUT_EN
      , .CNT(cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [21:0] pack(input int a, input int b, input int c, input int d, input int n);
      return {4'(a), 4'(b), 4'(c), 4'(d), 6'(n)};
   endfunction

   // scoreboard: compare on each DONE pulse
   always @(negedge clk) begin
      if (!rst && done) begin
         logic [21:0] e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("c1x", c1x, e[21:18]);
            chk("c1y", c1y, e[17:14]);
            chk("c2x", c2x, e[13:10]);
            chk("c2y", c2y, e[9:6]);
`ifdef LASER_COUNT_OUT_EN
            chk("cnt", cnt, e[5:0]);
`endif
         end
      end
   end

   // driver tasks
   task automatic load_pts(input int mode, input bit bubbles);
      for (int i = 0; i < NPTS; i++) begin
         if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               x = 4'($urandom_range(0, 15));
               y = 4'($urandom_range(0, 15));
               @(negedge clk);
            end
         end
         in_valid = 1'b1;
         case (mode)
            0:       begin x = 4'd8;  y = 4'd8;  end
            1:       begin x = (i % 2) ? 4'd13 : 4'd2; y = x; end
            default: begin x = 4'd15; y = 4'd15; end
         endcase
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("ready_drop", ready, 32'd0);
   endtask

   task automatic wait_done(input bit noisy);
      int lat, viol;
      lat = 0;
      viol = 0;
      while (!done && lat < LIMIT) begin
         in_valid = noisy;
         x = 4'($urandom_range(0, 15));
         y = 4'($urandom_range(0, 15));
         @(negedge clk);
         lat++;
         if (!done) begin
            if (ready) viol++;
            if ({c1x, c1y, c2x, c2y} !== prev_exp[21:6]) viol++;
         end
      end
      in_valid = 1'b0;
      chk("done_seen", done, 32'd1);
      chk("latency_ok", 32'(lat <= BOUND), 32'd1);
      chk("ready_at_done", ready, 32'd0);
      chk("busy_viol", 32'(viol), 32'd0);
      @(negedge clk);
      chk("done_pulse", done, 32'd0);
      chk("ready_after", ready, 32'd1);
   endtask

   task automatic job(input int mode, input bit bubbles, input bit noisy, input logic [21:0] e);
      exp_q.push_back(e);
      load_pts(mode, bubbles);
      wait_done(noisy);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      prev_exp = e;
   endtask

   initial begin
      logic [21:0] e1, e2, e3;
      int d0;
      e1 = pack(8, 4, 0, 0, 40);
      e2 = pack(0, 0, 13, 9, 40);
      e3 = pack(15, 11, 0, 0, 40);
      prev_exp = '0;
      rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready, 32'd1);
      chk("rst_done", done, 32'd0);
      chk("rst_c", {c1x, c1y, c2x, c2y}, 32'd0);
`ifdef LASER_COUNT_OUT_EN
      chk("rst_cnt", cnt, 32'd0);
`endif

      job(0, 1'b0, 1'b0, e1);
      job(1, 1'b0, 1'b0, e2);
      job(2, 1'b0, 1'b0, e3);
      job(1, 1'b1, 1'b1, e2);

      // reset mid-SWEEP2
      d0 = done_cnt;
      load_pts(0, 1'b0);
      repeat (300) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_c", {c1x, c1y, c2x, c2y}, 32'd0);
      chk("midrst_ready", ready, 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("midrst_ready2", ready, 32'd1);
      prev_exp = '0;
      job(0, 1'b0, 1'b0, e1);

      // back-to-back jobs
      job(0, 1'b0, 1'b0, e1);
      job(1, 1'b0, 1'b0, e2);
      chk("done_total", 32'(done_cnt), 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
